// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: one shared bitwise logic unit serving
// four requesters through a round-robin arbiter.
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] op_a,
  input  logic [4*WIDTH-1:0] op_b,
  input  logic [11:0]        op_sel,
  output logic [3:0]         gnt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  state_t           state_q;
  logic [1:0]       rr_ptr_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [1:0]       id_q;

  logic             win_ok;
  logic [1:0]       win_id;
  logic [1:0]       idx;
  logic [WIDTH-1:0] res_d;
  logic             err_d;

  // Round-robin search: the lowest offset from rr_ptr wins,
  // so walk offsets high to low and let the last hit stand.
  always_comb begin
    win_ok = 1'b0;
    win_id = rr_ptr_q;
    idx    = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr_q + 2'(k);
      if (req[idx]) begin
        win_ok = 1'b1;
        win_id = idx;
      end
    end
  end

  // Shared gate unit, fed only from the latched operands.
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (op_q)
      OP_AND:  res_d = a_q & b_q;
      OP_NAND: res_d = ~(a_q & b_q);
      OP_OR:   res_d = a_q | b_q;
      OP_NOR:  res_d = ~(a_q | b_q);
      OP_NOT:  res_d = ~a_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_XNOR: res_d = ~(a_q ^ b_q);
      default: begin
        res_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  // Grant / execute / respond sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      gnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'd0;
      id_q      <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt <= 4'd0;
          if (win_ok) begin
            gnt     <= 4'(4'b0001 << win_id);
            a_q     <= op_a[win_id*WIDTH +: WIDTH];
            b_q     <= op_b[win_id*WIDTH +: WIDTH];
            op_q    <= op_sel[win_id*3 +: 3];
            id_q    <= win_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          gnt       <= 4'd0;
          rsp_data  <= res_d;
          rsp_err   <= err_d;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_q  <= id_q + 2'd1;
            state_q   <= IDLE;
          end
        end
        default: begin
          gnt       <= 4'd0;
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed vectors plus a transaction
// model compared against the DUT every cycle.
module tb_logic_op_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] op_a;
  logic [4*W-1:0] op_b;
  logic [11:0]    op_sel;
  logic [3:0]     gnt;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  int errors = 0;
  int checks = 0;

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Result of one operation from the opcode table: {err, data}.
  function automatic logic [W:0] alu(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, ~(a & b)};
      3'd2: return {1'b0, a | b};
      3'd3: return {1'b0, ~(a | b)};
      3'd4: return {1'b0, ~a};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, ~(a ^ b)};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  // Transaction model: a pending job walks granted -> responding.
  bit           started = 0;
  int           phase = 0;
  int           ptr = 0;
  int           t_id = 0;
  logic [W-1:0] t_a, t_b;
  logic [2:0]   t_op;
  logic [3:0]   e_gnt = '0;
  logic         e_valid = 0;
  logic [1:0]   e_id = '0;
  logic [W-1:0] e_data = '0;
  logic         e_err = 0;
  logic [W:0]   r;

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      phase = 0; ptr = 0;
      e_gnt = '0; e_valid = 0;
      e_id = '0; e_data = '0; e_err = 0;
    end else if (phase == 0) begin
      e_gnt = '0;
      for (int k = 0; k < 4; k++) begin
        if (phase == 0 && req[(ptr + k) % 4]) begin
          t_id  = (ptr + k) % 4;
          t_a   = op_a[t_id*W +: W];
          t_b   = op_b[t_id*W +: W];
          t_op  = op_sel[t_id*3 +: 3];
          e_gnt = 4'(1 << t_id);
          phase = 1;
        end
      end
    end else if (phase == 1) begin
      r = alu(t_op, t_a, t_b);
      e_gnt = '0;
      e_valid = 1;
      e_id = 2'(t_id);
      e_data = r[W-1:0];
      e_err = r[W];
      phase = 2;
    end else if (rsp_ready) begin
      e_valid = 0;
      ptr = (t_id + 1) % 4;
      phase = 0;
    end
  end

  // Grant log and per-cycle comparison against the model.
  int glog[$];

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("m_gnt", gnt, e_gnt);
      chk("m_valid", rsp_valid, e_valid);
      chk("m_id", rsp_id, e_id);
      chk("m_data", rsp_data, e_data);
      chk("m_err", rsp_err, e_err);
      for (int i = 0; i < 4; i++)
        if (gnt[i]) glog.push_back(i);
    end
  end

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (gnt != 0) begin
        g = gnt;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input int rq,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [2:0] op,
                        output logic [W-1:0] d,
                        output logic [1:0] id,
                        output logic er);
    logic [3:0] g;
    @(negedge clk);
    op_a[rq*W +: W] = a;
    op_b[rq*W +: W] = b;
    op_sel[rq*3 +: 3] = op;
    rsp_ready = 1;
    req = 4'(1 << rq);
    wait_gnt(g);
    chk("op_gnt", g, 4'(1 << rq));
    @(negedge clk);
    req = '0;
    wait_valid();
    d = rsp_data; id = rsp_id; er = rsp_err;
    @(posedge clk); #1;
    chk("op_done", rsp_valid, 0);
  endtask

  logic [W-1:0] exp_tab [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03,
                                8'h0F, 8'h3C, 8'hC3, 8'h00};
  int           rr_exp [6] = '{0, 1, 2, 3, 0, 3};

  initial begin
    logic [W-1:0] d, hd;
    logic [1:0]   id;
    logic         er;
    logic [3:0]   g;
    rst = 1; req = '0; rsp_ready = 0;
    op_a = '0; op_b = '0; op_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // single XOR on requester 1
    run_op(1, 8'hC3, 8'hA5, 3'd5, d, id, er);
    chk("xor_data", d, 8'h66);
    chk("xor_id", id, 1);
    chk("xor_err", er, 0);

    // every opcode on requester 0
    for (int o = 0; o < 8; o++) begin
      run_op(0, 8'hF0, 8'hCC, 3'(o), d, id, er);
      chk("tab_data", d, exp_tab[o]);
      chk("tab_err", er, o == 7);
      chk("tab_id", id, 0);
    end

    // reset with all requesting, then round-robin
    @(negedge clk);
    rst = 1; req = 4'b1111;
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    op_sel = 12'b110_101_011_010;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
    end
    @(negedge clk);
    rst = 0;
    glog.delete();
    for (int n = 0; n < 5; n++) wait_gnt(g);
    @(negedge clk);
    req = 4'b1001;
    wait_gnt(g);
    chk("rr_len", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk("rr_order", glog[i], rr_exp[i]);

    // backpressure
    @(negedge clk);
    rsp_ready = 0; req = 4'b1111;
    wait_valid();
    hd = rsp_data; id = rsp_id;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, hd);
      chk("bp_id", rsp_id, id);
      chk("bp_gnt", gnt, 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_done", rsp_valid, 0);
    chk("bp_idle_gnt", gnt, 0);
    @(posedge clk); #1;
    chk("bp_next_gnt", gnt, 4'(1 << ((id + 1) % 4)));

    // reset while a response is held
    @(negedge clk);
    rsp_ready = 0; req = 4'b0100;
    wait_valid();
    @(negedge clk);
    rst = 1; req = '0;
    @(posedge clk); #1;
    chk("mr_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mr_quiet", rsp_valid, 0);
    end
    @(negedge clk);
    req = 4'b1111;
    wait_gnt(g);
    chk("mr_first_gnt", g, 4'b0001);
    @(negedge clk);
    req = '0;
    repeat (4) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit between 4 requesters.
- The unit supports AND, NAND, OR, NOR, NOT, XOR and XNOR.
- A round-robin arbiter picks one request at a time and latches its operands and opcode.
- The registered result is returned with the winner's ID on a valid/ready response channel, which sits between the requesting datapath blocks and the shared gate unit.

Parameters:
- WIDTH, 8, operand and result width in bits. Requester count is fixed at 4; IDs are 2 bits.

Ports:
- clk  in  1  single rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  request per requester; held high with operands stable until its gnt bit pulses
- op_a  in  4*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- op_b  in  4*WIDTH  operand B; same slicing
- op_sel  in  12  opcode; requester i uses slice [i*3 +: 3]
- gnt  out  4  one-hot grant, registered, one-cycle pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  2  index of the requester being served
- rsp_data  out  WIDTH  result
- rsp_err  out  1  illegal opcode flag

Behaviour:
- Reset (synchronous):
  - state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr_ptr=0.
  - A reset mid-transaction drops the transaction; no response is issued.
- Opcodes:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT (~a, b ignored), 5 XOR, 6 XNOR.
  - 7 is illegal: rsp_data=0, rsp_err=1.
  - rsp_err=0 for all legal opcodes.
- State IDLE:
  - On a clk edge with req!=0, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... mod 4.
  - At that edge: gnt[winner]=1; operands, opcode and ID are latched; state goes to EXEC.
  - With req==0 the block stays in IDLE and gnt stays 0.
- State EXEC (1 cycle):
  - At the next edge: gnt=0; rsp_data, rsp_err and rsp_id are registered from the latched values; rsp_valid=1; state goes to RESP.
- State RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err hold stable until rsp_ready=1 at an edge.
  - At that edge: rsp_valid=0, rr_ptr=(winner+1) mod 4, state goes to IDLE.
  - rsp_data, rsp_id and rsp_err keep their last values while rsp_valid=0.
- Latency and throughput:
  - req sampled at edge N, gnt high after edge N, rsp_valid high after edge N+1.
  - Earliest completion is at edge N+2 (rsp_ready already high).
  - Maximum throughput is one operation per 3 cycles.
- Requester contract:
  - Drop req (or present the next request) after seeing gnt.
  - req is not sampled in EXEC or RESP, so a stale req during those states is harmless.
- Fairness:
  - rr_ptr advances only on response completion, never on grant.
  - With all 4 requesting continuously, grants cycle 0,1,2,3,0,...
- Simultaneous events:
  - rst wins over everything.
  - In RESP, changes to req do not affect the held response.
  - Operand or req changes after the grant edge do not affect the result.
- rsp_ready is ignored outside RESP.
- No combinational path from any input to any output.

Test Plan:
- Reset check: assert rst for 2 cycles with req=4'b1111 -> gnt=0, rsp_valid=0, rsp_data=0 and rr_ptr=0 throughout reset; first grant after reset goes to requester 0.
- Single op: req=4'b0010, requester 1 presents a=8'hC3, b=8'hA5, op=5 (XOR), rsp_ready=1 -> gnt=4'b0010 for one cycle, then rsp_valid=1 for one cycle with rsp_id=1, rsp_data=8'h66, rsp_err=0.
- All opcodes: requester 0, a=8'hF0, b=8'hCC, opcodes 0..7:
  - expected rsp_data 8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h0F, 8'h3C, 8'hC3, 8'h00;
  - rsp_err=1 only for opcode 7.
- Round-robin: req=4'b1111 held, each requester re-asserting after its grant -> grant order 0,1,2,3,0; then req=4'b1001 after serving 0 -> next grant goes to 3.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_data stay stable, no new gnt even with req=4'b1111; raise rsp_ready -> completion, and the next grant occurs 1 cycle after return to IDLE.
- Mid-operation reset: assert rst in RESP with rsp_valid=1 -> next cycle rsp_valid=0, state IDLE, rr_ptr=0; the dropped response never reappears.
